// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier: controller state encoding
// and the default operand width.
package mult_pkg;

    localparam int unsigned MULT_N = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Moore controller for the shift-and-add multiplier: tests the multiplier LSB each
// iteration and issues load/clear/add/shift strobes, then pulses done.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned N          = MULT_N,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic lsb_b,
    input  logic z_b,
    output logic init_sh_r,
    output logic acc_clr,
    output logic add_en,
    output logic sh_en,
    output logic busy,
    output logic done
);

    // A single-bit counter still works for N=1 (it only ever holds 0).
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end
            S_INIT: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (EARLY_EXIT && z_b) begin
                    state_d = S_DONE;
                end else if (lsb_b) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CHECK;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs depend on the state register alone.
    always_comb begin
        init_sh_r = 1'b0;
        acc_clr   = 1'b0;
        add_en    = 1'b0;
        sh_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_INIT: begin
                init_sh_r = 1'b1;
                acc_clr   = 1'b1;
                busy      = 1'b1;
            end
            S_CHECK: begin
                busy = 1'b1;
            end
            S_ADD: begin
                add_en = 1'b1;
                busy   = 1'b1;
            end
            S_SHIFT: begin
                sh_en = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: two instances (EARLY_EXIT 0 and 1), each fed by a
// small sh_r model, with the state trace decoded from the Moore outputs.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: EARLY_EXIT=0; instance 1: EARLY_EXIT=1.
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [2:0] b_val0 = '0, b_val1 = '0;
    logic [2:0] b0_q = '0, b1_q = '0;
    logic init0, clr0, add0, sh0, busy0, done0;
    logic init1, clr1, add1, sh1, busy1, done1;

    mult_seq_ctrl #(.N(3), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .lsb_b(b0_q[0]), .z_b(b0_q == 3'd0),
        .init_sh_r(init0), .acc_clr(clr0), .add_en(add0), .sh_en(sh0),
        .busy(busy0), .done(done0)
    );

    mult_seq_ctrl #(.N(3), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .lsb_b(b1_q[0]), .z_b(b1_q == 3'd0),
        .init_sh_r(init1), .acc_clr(clr1), .add_en(add1), .sh_en(sh1),
        .busy(busy1), .done(done1)
    );

    // sh_r model: load on init_sh_r, shift right on sh_en.
    always @(posedge clk) begin
        if (init0) b0_q <= b_val0;
        else if (sh0) b0_q <= b0_q >> 1;
        if (init1) b1_q <= b_val1;
        else if (sh1) b1_q <= b1_q >> 1;
    end

    // Bench-side state codes; 7 flags an illegal output combination.
    localparam int T_IDLE = 0, T_INIT = 1, T_CHECK = 2, T_ADD = 3, T_SHIFT = 4, T_DONE = 5;
    localparam int T_BAD = 7;

    int asserts = 0;
    int fails   = 0;
    int exp_q[$];

    function automatic int decode(input int which);
        logic [5:0] v;
        v = (which == 0) ? {init0, clr0, add0, sh0, busy0, done0}
                         : {init1, clr1, add1, sh1, busy1, done1};
        case (v)
            6'b000000: return T_IDLE;
            6'b110010: return T_INIT;
            6'b000010: return T_CHECK;
            6'b001010: return T_ADD;
            6'b000110: return T_SHIFT;
            6'b000011: return T_DONE;
            default:   return T_BAD;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        asserts++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start on one instance, then compare each cycle's decoded state with exp_q,
    // one further IDLE cycle, and the strobe pulse counts.
    task automatic run_seq(input int which, input logic [2:0] b, input string tag,
                           input int n_add, input int n_sh);
        int st, c_add, c_sh, c_init;
        c_add = 0; c_sh = 0; c_init = 0;
        @(negedge clk);
        if (which == 0) begin b_val0 = b; start0 = 1'b1; end
        else begin b_val1 = b; start1 = 1'b1; end
        foreach (exp_q[i]) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            st = decode(which);
            chk($sformatf("%s.cyc%0d", tag, i + 1), st, exp_q[i]);
            if (st == T_ADD)   c_add++;
            if (st == T_SHIFT) c_sh++;
            if (st == T_INIT)  c_init++;
        end
        @(negedge clk);
        chk($sformatf("%s.idle_after", tag), decode(which), T_IDLE);
        chk($sformatf("%s.n_add", tag), c_add, n_add);
        chk($sformatf("%s.n_sh", tag), c_sh, n_sh);
        chk($sformatf("%s.n_init", tag), c_init, 1);
    endtask

    initial begin
        // Reset state.
        #12;
        chk("reset.dut0", decode(0), T_IDLE);
        chk("reset.dut1", decode(1), T_IDLE);
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-run: abort dut0 while it sits in ADD.
        @(negedge clk);
        b_val0 = 3'd5;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.in_add", decode(0), T_ADD);
        #1 rst = 1'b0;
        #1;
        chk("midrst.outs_zero", decode(0), T_IDLE);
        @(negedge clk);
        chk("midrst.held", decode(0), T_IDLE);
        rst = 1'b1;

        // EARLY_EXIT=0, B=5: done in cycle 10.
        exp_q = '{T_INIT, T_CHECK, T_ADD, T_SHIFT, T_CHECK, T_SHIFT, T_CHECK, T_ADD,
                  T_SHIFT, T_DONE};
        run_seq(0, 3'd5, "ee0_b5", 2, 3);

        // EARLY_EXIT=1, B=1: exits on z_b after one shift, done in cycle 6.
        exp_q = '{T_INIT, T_CHECK, T_ADD, T_SHIFT, T_CHECK, T_DONE};
        run_seq(1, 3'd1, "ee1_b1", 1, 1);

        // EARLY_EXIT=1, B=0: immediate exit, done in cycle 3.
        exp_q = '{T_INIT, T_CHECK, T_DONE};
        run_seq(1, 3'd0, "ee1_b0", 0, 0);

        // EARLY_EXIT=0, B=7: done in cycle 11.
        exp_q = '{T_INIT, T_CHECK, T_ADD, T_SHIFT, T_CHECK, T_ADD, T_SHIFT, T_CHECK, T_ADD,
                  T_SHIFT, T_DONE};
        run_seq(0, 3'd7, "ee0_b7", 3, 3);

        // EARLY_EXIT=0, B=0: no early exit, all three shifts still happen.
        exp_q = '{T_INIT, T_CHECK, T_SHIFT, T_CHECK, T_SHIFT, T_CHECK, T_SHIFT, T_DONE};
        run_seq(0, 3'd0, "ee0_b0", 0, 3);

        // start held high: two back-to-back B=5 runs, one IDLE cycle between them;
        // start toggles mid-run but is high on the IDLE edge.
        exp_q = '{T_INIT, T_CHECK, T_ADD, T_SHIFT, T_CHECK, T_SHIFT, T_CHECK, T_ADD,
                  T_SHIFT, T_DONE, T_IDLE,
                  T_INIT, T_CHECK, T_ADD, T_SHIFT, T_CHECK, T_SHIFT, T_CHECK, T_ADD,
                  T_SHIFT, T_DONE, T_IDLE};
        @(negedge clk);
        b_val0 = 3'd5;
        start0 = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            chk($sformatf("b2b.cyc%0d", i + 1), decode(0), exp_q[i]);
            if (i == 10) start0 = 1'b1;
            else if (i == 21) start0 = 1'b0;
            else start0 = (i % 2) == 0;
        end
        @(negedge clk);
        chk("b2b.stays_idle", decode(0), T_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
